ldpc_out_serializer: RTL and testbench
======================================

LDPC_OUT_SERIALIZER -- requirements
Module: ldpc_out_serializer

Interface
REQ-001 SHALL have parameter N_BITS, default 768, meaning decoded codeword length in bits.
REQ-002 SHALL have parameter W, default 32, meaning output word width; N_BITS SHALL be an integer multiple of W, and WORDS = N_BITS/W.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 load_vout  input  1  single-cycle pulse from the decode controller: capture vout.
REQ-006 vout  input  N_BITS  hard-decision codeword from the NMS core.
REQ-007 en_out  input  1  controller output-enable.
REQ-008 shift_out  input  1  controller shift permission.
REQ-009 rst_flag  input  1  active-low synchronous clear from the controller.
REQ-010 dout_ready  input  1  downstream sink accepts a word.
REQ-011 dout  output  W  current output word.
REQ-012 dout_valid  output  1  dout holds a valid word.
REQ-013 dout_last  output  1  current word is word WORDS-1.
REQ-014 f_out  output  1  all words transferred; fed back to the controller.
REQ-015 busy  output  1  state is not IDLE.
REQ-016 err_ovr  output  1  sticky overrun flag.

Function
REQ-017 SHALL implement three states (IDLE, SEND, DONE) plus an N_BITS shift buffer and a word counter wcnt of width clog2(WORDS).
REQ-018 In IDLE, when load_vout=1: capture vout into the buffer, set wcnt=0, and enter SEND on the next edge.
REQ-019 In IDLE, dout_valid=0, f_out=0, busy=0.
REQ-020 dout SHALL equal buffer[W-1:0], so word 0 = vout[W-1:0] is sent first (LSW first).
REQ-021 dout_valid SHALL be (state==SEND) & en_out, combinational from registered state.
REQ-022 dout_last SHALL be dout_valid & (wcnt==WORDS-1).
REQ-023 A transfer occurs on an edge where dout_valid & dout_ready & shift_out = 1.
REQ-024 On each transfer, the buffer shifts right by W (zero fill) and wcnt increments by 1.
REQ-025 Without a transfer, the buffer, wcnt and dout SHALL hold; no data is lost under backpressure.
REQ-026 A transfer with wcnt==WORDS-1 SHALL enter DONE; wcnt SHALL NOT wrap within SEND.
REQ-027 In DONE, f_out=1 (level) and dout_valid=0; DONE holds until rst_flag=0.
REQ-028 rst_flag=0 sampled in any state SHALL return to IDLE next edge: wcnt=0, buffer cleared, err_ovr cleared.
REQ-029 rst_flag=0 and load_vout=1 on the same edge: clear wins, load is ignored.
REQ-030 load_vout=1 in SEND or DONE SHALL be ignored for data and SHALL set err_ovr=1 (sticky until rst_flag=0 or reset).
REQ-031 shift_out=1 or en_out=1 in IDLE or DONE SHALL have no effect.
REQ-032 Latency: first word valid on the cycle after the capture edge if en_out=1; minimum WORDS cycles from first dout_valid to f_out=1.

Reset
REQ-033 rst_n=0 SHALL asynchronously force state=IDLE, buffer=0, wcnt=0, dout=0, dout_valid=0, dout_last=0, f_out=0, busy=0, err_ovr=0.
REQ-034 Reset asserted mid-SEND SHALL abort the transfer with no further dout_valid until a new load_vout.
REQ-035 After rst_n deasserts, the block SHALL respond to load_vout on the first rising edge.

Verification
REQ-036 Basic: vout word i = 32'hA5A50000+i; load; en_out=shift_out=dout_ready=1 -> 24 words 32'hA5A50000..32'hA5A50017 in order, dout_last only on word 23, f_out=1 the cycle after; rst_flag=0 pulse -> IDLE.
REQ-037 Backpressure: toggle dout_ready 1,0,0,1,... -> each word held stable while ready=0; word sequence identical to REQ-036; f_out only after word 23 is accepted.
REQ-038 Gating: shift_out=0 or en_out=0 for 5 cycles mid-frame -> no wcnt advance, dout_valid=0 while en_out=0, and the word is resumed correctly.
REQ-039 Overrun: second load_vout with vout=all-ones during SEND -> err_ovr=1 and the output stream still carries the original data; rst_flag=0 -> err_ovr=0.
REQ-040 Abort: rst_n=0 after word 10 -> all outputs 0 immediately; new load then sends word 0 of the new vout first.
REQ-041 Simultaneous: rst_flag=0 with load_vout=1 in IDLE -> stays IDLE, busy=0, dout_valid=0.

Source files
------------

// File: rtl/ldpc_out_serializer.sv
// Serialises a captured N_BITS hard-decision codeword into WORDS words of W bits,
// least-significant word first, with ready/valid flow control and controller gating.
module ldpc_out_serializer #(
  parameter int N_BITS = 768,
  parameter int W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_vout,
  input  logic [N_BITS-1:0] vout,
  input  logic              en_out,
  input  logic              shift_out,
  input  logic              rst_flag,
  input  logic              dout_ready,
  output logic [W-1:0]      dout,
  output logic              dout_valid,
  output logic              dout_last,
  output logic              f_out,
  output logic              busy,
  output logic              err_ovr
);

  localparam int WORDS = N_BITS / W;
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [N_BITS-1:0] sh_buf;
  logic [CNT_W-1:0]  wcnt;
  logic              err_q;
  logic              xfer;
  logic              at_last;

  assign at_last    = (wcnt == LAST_WORD);
  assign dout       = sh_buf[W-1:0];
  assign dout_valid = (state == SEND) & en_out;
  assign dout_last  = dout_valid & at_last;
  assign xfer       = dout_valid & dout_ready & shift_out;
  assign f_out      = (state == DONE);
  assign busy       = (state != IDLE);
  assign err_ovr    = err_q;

  // Controller clear (rst_flag low) overrides everything, including a coincident load.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load_vout) state_nxt = SEND;
      SEND:    if (xfer && at_last) state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    if (!rst_flag) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_buf <= '0;
      wcnt   <= '0;
    end else if (!rst_flag) begin
      sh_buf <= '0;
      wcnt   <= '0;
    end else if (state == IDLE && load_vout) begin
      sh_buf <= vout;
      wcnt   <= '0;
    end else if (xfer) begin
      sh_buf <= sh_buf >> W;
      // Counter parks on the last index so it never wraps inside a frame.
      if (!at_last) wcnt <= wcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           err_q <= 1'b0;
    else if (!rst_flag)                   err_q <= 1'b0;
    else if (load_vout && state != IDLE)  err_q <= 1'b1;
  end

endmodule

// File: tb/tb_ldpc_out_serializer.sv
// Scoreboard bench for ldpc_out_serializer: expected words are queued at load time
// and compared against every accepted output transfer.
module tb_ldpc_out_serializer;

  localparam int N_BITS = 768;
  localparam int W      = 32;
  localparam int WORDS  = N_BITS / W;
  localparam int LIMIT  = 400;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              load_vout;
  logic [N_BITS-1:0] vout;
  logic              en_out;
  logic              shift_out;
  logic              rst_flag;
  logic              dout_ready;
  logic [W-1:0]      dout;
  logic              dout_valid;
  logic              dout_last;
  logic              f_out;
  logic              busy;
  logic              err_ovr;

  int n_checks = 0;
  int n_errors = 0;
  logic [W:0] exp_q[$];

  ldpc_out_serializer #(.N_BITS(N_BITS), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .load_vout(load_vout), .vout(vout),
    .en_out(en_out), .shift_out(shift_out), .rst_flag(rst_flag),
    .dout_ready(dout_ready), .dout(dout), .dout_valid(dout_valid),
    .dout_last(dout_last), .f_out(f_out), .busy(busy), .err_ovr(err_ovr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N_BITS-1:0] mk_frame(input int kind);
    logic [N_BITS-1:0] v;
    logic [W-1:0] w;
    v = '0;
    for (int i = 0; i < WORDS; i++) begin
      case (kind)
        0:       w = 32'hA5A50000 + i;
        1:       w = 32'h3C000000 + i * 32'h00010203;
        default: w = '1;
      endcase
      v[i*W +: W] = w;
    end
    return v;
  endfunction

  task automatic load_frame(input logic [N_BITS-1:0] v, input bit expect_data);
    vout      = v;
    load_vout = 1'b1;
    if (expect_data)
      for (int i = 0; i < WORDS; i++)
        exp_q.push_back({(i == WORDS - 1), v[i*W +: W]});
    tick();
    load_vout = 1'b0;
  endtask

  // mode 0: sink always ready; mode 1: ready pattern 1,0,0 repeating
  task automatic run_frame(input int mode, output int cycles);
    cycles = 0;
    while (!f_out && cycles < LIMIT) begin
      dout_ready = (mode == 0) ? 1'b1 : ((cycles % 3) == 0);
      tick();
      cycles++;
    end
    dout_ready = 1'b1;
    check("frame_done", f_out, 1'b1);
    check("queue_empty_at_done", exp_q.size(), 0);
  endtask

  task automatic clear_pulse();
    rst_flag = 1'b0;
    tick();
    rst_flag = 1'b1;
  endtask

  // Transfer monitor: sampled on the falling edge, ahead of the edge that commits it.
  logic       hold_pending = 1'b0;
  logic [W:0] held;
  always @(negedge clk) begin
    if (!rst_n || !dout_valid) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) check("hold_stable", {dout_last, dout}, held);
      if (dout_ready && shift_out) begin
        hold_pending = 1'b0;
        if (exp_q.size() == 0) check("unexpected_word", {dout_last, dout}, '0);
        else check("word", {dout_last, dout}, exp_q.pop_front());
      end else begin
        hold_pending = 1'b1;
        held = {dout_last, dout};
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int sz;
    rst_n = 1'b0; load_vout = 1'b0; vout = '0; en_out = 1'b1;
    shift_out = 1'b1; rst_flag = 1'b1; dout_ready = 1'b1;
    repeat (2) tick();
    check("rst_outputs", {dout, dout_valid, dout_last, f_out, busy, err_ovr}, '0);
    rst_n = 1'b1;

    // Basic frame at full throughput
    load_frame(mk_frame(0), 1'b1);
    check("first_valid", dout_valid, 1'b1);
    check("first_word", dout, 32'hA5A50000);
    run_frame(0, k);
    check("basic_latency", k, WORDS);
    tick();
    check("done_no_valid", dout_valid, 1'b0);
    check("done_f_hold", f_out, 1'b1);
    clear_pulse();
    check("clear_idle", {busy, f_out, dout_valid}, 3'b000);

    // Backpressure
    load_frame(mk_frame(0), 1'b1);
    run_frame(1, k);
    check("bp_min_cycles", (k >= WORDS), 1'b1);
    clear_pulse();

    // Gating mid-frame
    load_frame(mk_frame(1), 1'b1);
    repeat (8) tick();
    shift_out = 1'b0;
    sz = exp_q.size();
    repeat (5) tick();
    check("shift_gate_hold", exp_q.size(), sz);
    shift_out = 1'b1;
    en_out = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("en_gate_invalid", dout_valid, 1'b0);
    end
    check("en_gate_hold", exp_q.size(), sz);
    en_out = 1'b1;
    run_frame(0, k);
    clear_pulse();

    // Overrun: second load during SEND
    load_frame(mk_frame(0), 1'b1);
    repeat (3) tick();
    check("no_err_yet", err_ovr, 1'b0);
    load_frame(mk_frame(2), 1'b0);
    check("err_set", err_ovr, 1'b1);
    run_frame(0, k);
    check("err_sticky", err_ovr, 1'b1);
    clear_pulse();
    check("err_cleared", err_ovr, 1'b0);

    // Asynchronous abort after word 10
    load_frame(mk_frame(1), 1'b1);
    k = 0;
    while (exp_q.size() > WORDS - 11 && k < LIMIT) begin
      tick();
      k++;
    end
    check("abort_reached", exp_q.size(), WORDS - 11);
    rst_n = 1'b0;
    #1;
    check("abort_outputs", {dout, dout_valid, dout_last, f_out, busy, err_ovr}, '0);
    exp_q.delete();
    repeat (2) tick();
    check("abort_no_valid", dout_valid, 1'b0);
    rst_n = 1'b1;
    load_frame(mk_frame(0), 1'b1);
    check("new_word0", dout, 32'hA5A50000);
    run_frame(0, k);
    clear_pulse();

    // Clear coincident with load in IDLE
    rst_flag  = 1'b0;
    load_vout = 1'b1;
    vout      = mk_frame(2);
    tick();
    rst_flag  = 1'b1;
    load_vout = 1'b0;
    check("simul_idle", {busy, dout_valid, f_out}, 3'b000);
    check("simul_no_capture", dout, '0);
    tick();
    check("simul_stays_idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
